// File: rtl/xt_hbus_rr_arbiter_pkg.sv
// XT high-speed bus shared types, constants and address helpers.
// Used by the round-robin arbiter and its picker.
package xt_hbus_rr_arbiter_pkg;

    localparam int unsigned HB_ADDR_WIDTH   = 15;
    localparam int unsigned HB_ID_WIDTH     = 3;
    localparam int unsigned HB_OFFSET_WIDTH = HB_ADDR_WIDTH - HB_ID_WIDTH;
    localparam int unsigned HB_NUM_SLAVES   = 2 ** HB_ID_WIDTH;
    localparam logic [31:0] HB_DECERR_DATA  = 32'hDEADBEEF;

    typedef struct packed {
        logic                     read;
        logic                     write;
        logic [HB_ADDR_WIDTH-1:0] raddr;
        logic [HB_ADDR_WIDTH-1:0] waddr;
        logic [31:0]              wdata;
        logic [1:0]               write_width;
    } hb_master_in_t;

    typedef struct packed {
        logic [HB_ADDR_WIDTH-1:0] raddr;
        logic [HB_ADDR_WIDTH-1:0] waddr;
        logic [31:0]              wdata;
        logic [1:0]               write_width;
    } hb_slave_t;

    typedef struct packed {
        logic        grant;
        logic        rvalid;
        logic [31:0] rdata;
    } hb_master_out_t;

    // Slave ID lives in the top bits of the address.
    function automatic logic [HB_ID_WIDTH-1:0] HB_GetID(input logic [HB_ADDR_WIDTH-1:0] addr);
        return addr[HB_ADDR_WIDTH-1 -: HB_ID_WIDTH];
    endfunction

    function automatic logic [HB_OFFSET_WIDTH-1:0] HB_GetOffset(
        input logic [HB_ADDR_WIDTH-1:0] addr
    );
        return addr[HB_OFFSET_WIDTH-1:0];
    endfunction

    function automatic logic [HB_NUM_SLAVES-1:0] HB_IDToOneHot(input logic [HB_ID_WIDTH-1:0] id);
        logic [HB_NUM_SLAVES-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/xt_hbus_rr_arbiter_picker.sv
// Round-robin picker: first requester at or after ptr, wrapping modulo N.
module xt_hbus_rr_picker #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        int unsigned      cand;
        logic [IDX_W-1:0] cand_idx;
        grant    = '0;
        idx      = '0;
        valid    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand     = (32'(ptr) + k) % N;
            cand_idx = IDX_W'(cand);
            if (!valid && req[cand_idx]) begin
                valid           = 1'b1;
                grant[cand_idx] = 1'b1;
                idx             = cand_idx;
            end
        end
    end

endmodule

// File: rtl/xt_hbus_rr_arbiter.sv
// N-master round-robin arbiter, ID decoder and read-return router for XT_HB.
// Optional decode-error reporting (m_err port) is enabled by defining XT_HB_DECERR_EN.
module xt_hbus_rr_arbiter
    import xt_hbus_rr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MASTERS  = 2,
    parameter int unsigned ADDR_WIDTH   = 15,
    parameter int unsigned ID_WIDTH     = 3,
    parameter int unsigned READ_LATENCY = 1,
    parameter logic [7:0]  SLAVE_MAP    = 8'hFF,
    localparam int unsigned NUM_SLAVES  = 2 ** ID_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  hb_master_in_t          m_in [NUM_MASTERS],
    output logic [NUM_MASTERS-1:0] m_grant,
    output logic [NUM_MASTERS-1:0] m_rvalid,
    output logic [31:0]            m_rdata,
`ifdef XT_HB_DECERR_EN
    output logic [NUM_MASTERS-1:0] m_err,
`endif
    output hb_slave_t              s_bus,
    output logic [NUM_SLAVES-1:0]  s_rd_sel,
    output logic [NUM_SLAVES-1:0]  s_wr_sel,
    input  logic [31:0]            s_rdata [NUM_SLAVES]
);

    localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef struct packed {
        logic                valid;
        logic                unmapped;
        logic [IDX_W-1:0]    idx;
        logic [ID_WIDTH-1:0] id;
    } ret_t;

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] pick_grant;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_valid;
    logic                   gnt_any;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    hb_master_in_t          gm;
    logic [ADDR_WIDTH-1:0]  rd_addr, wr_addr;
    logic [ID_WIDTH-1:0]    rd_id, wr_id;
    logic                   rd_mapped, wr_mapped;
    logic                   do_read, do_write;
    ret_t                   pipe_q [READ_LATENCY];
    ret_t                   ret;

    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            req[i] = m_in[i].read | m_in[i].write;
        end
    end

    xt_hbus_rr_picker #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (req),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Outputs are forced quiet while reset is held, even if masters keep requesting.
    assign gnt_any   = pick_valid & rst_n;
    assign m_grant   = gnt_any ? pick_grant : '0;
    assign gm        = m_in[pick_idx];
    assign rd_addr   = gm.raddr;
    assign wr_addr   = gm.waddr;
    assign rd_id     = HB_GetID(rd_addr);
    assign wr_id     = HB_GetID(wr_addr);
    assign rd_mapped = SLAVE_MAP[rd_id];
    assign wr_mapped = SLAVE_MAP[wr_id];
    assign do_read   = gnt_any & gm.read;
    assign do_write  = gnt_any & gm.write;
    assign s_rd_sel  = (do_read && rd_mapped) ? HB_IDToOneHot(rd_id) : '0;
    assign s_wr_sel  = (do_write && wr_mapped) ? HB_IDToOneHot(wr_id) : '0;

    always_comb begin
        s_bus = '0;
        if (gnt_any) begin
            s_bus.raddr       = gm.raddr;
            s_bus.waddr       = gm.waddr;
            s_bus.wdata       = gm.wdata;
            s_bus.write_width = gm.write_width;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (NUM_MASTERS == 1) begin
            rr_ptr_d = '0;
        end else if (gnt_any) begin
            rr_ptr_d = (pick_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : pick_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            for (int s = 0; s < READ_LATENCY; s++) begin
                pipe_q[s] <= '0;
            end
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            pipe_q[0] <= ret_t'{valid: do_read, unmapped: ~rd_mapped, idx: pick_idx, id: rd_id};
            for (int s = 1; s < READ_LATENCY; s++) begin
                pipe_q[s] <= pipe_q[s-1];
            end
        end
    end

    assign ret = pipe_q[READ_LATENCY-1];

    always_comb begin
        m_rvalid = '0;
        m_rdata  = '0;
        if (ret.valid) begin
            m_rvalid[ret.idx] = 1'b1;
            if (!ret.unmapped) begin
                m_rdata = s_rdata[ret.id];
            end else begin
`ifdef XT_HB_DECERR_EN
                m_rdata = HB_DECERR_DATA;
`else
                m_rdata = '0;
`endif
            end
        end
    end

`ifdef XT_HB_DECERR_EN
    always_comb begin
        m_err = '0;
        if (do_write && !wr_mapped) begin
            m_err[pick_idx] = 1'b1;
        end
        if (ret.valid && ret.unmapped) begin
            m_err[ret.idx] = 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_xt_hbus_rr_arbiter.sv
// Self-checking bench for xt_hbus_rr_arbiter: directed cases plus randomized traffic
// against a transaction-level model; also covers the XT_HB_DECERR_EN build.
module tb_xt_hbus_rr_arbiter;
    import xt_hbus_rr_arbiter_pkg::*;

    localparam int         N   = 2;
    localparam int         L   = 2;
    localparam logic [7:0] MAP = 8'hDF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    hb_master_in_t m_in [N];
    logic [N-1:0]  m_grant, m_rvalid;
    logic [31:0]   m_rdata;
    hb_slave_t     s_bus;
    logic [7:0]    s_rd_sel, s_wr_sel;
    logic [31:0]   s_rdata [8];
`ifdef XT_HB_DECERR_EN
    logic [N-1:0]  m_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xt_hbus_rr_arbiter #(
        .NUM_MASTERS  (N),
        .ADDR_WIDTH   (15),
        .ID_WIDTH     (3),
        .READ_LATENCY (L),
        .SLAVE_MAP    (MAP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m_in     (m_in),
        .m_grant  (m_grant),
        .m_rvalid (m_rvalid),
        .m_rdata  (m_rdata),
`ifdef XT_HB_DECERR_EN
        .m_err    (m_err),
`endif
        .s_bus    (s_bus),
        .s_rd_sel (s_rd_sel),
        .s_wr_sel (s_wr_sel),
        .s_rdata  (s_rdata)
    );

    typedef struct {
        int due;
        int m;
        int id;
        bit unmapped;
    } ret_rec_t;

    ret_rec_t   rq[$];
    int         ptr = 0;
    int         cyc = 0;
    int         g_m = -1;
    bit         pend [N];
    logic [7:0] map_v = MAP;

    function automatic int hb_id(input logic [14:0] a);
        return int'(a) / 4096;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Model compare: outputs for the current cycle, sampled 1 time unit after the inputs change.
    task automatic settle();
        logic [N-1:0] eg, ev, ee;
        logic [7:0]   ers, ews;
        logic [31:0]  ed;
        int           best;
        #1;
        eg = '0; ev = '0; ee = '0; ers = '0; ews = '0; ed = '0;
        g_m = -1;
        if (!rst_n) begin
            rq.delete();
            ptr = 0;
        end else begin
            best = N;
            for (int i = 0; i < N; i++) begin
                if ((m_in[i].read || m_in[i].write) && ((i - ptr + N) % N) < best) begin
                    best = (i - ptr + N) % N;
                    g_m  = i;
                end
            end
        end
        if (g_m >= 0) begin
            eg[g_m] = 1'b1;
            if (m_in[g_m].read && map_v[hb_id(m_in[g_m].raddr)])
                ers = 8'b1 << hb_id(m_in[g_m].raddr);
            if (m_in[g_m].write && map_v[hb_id(m_in[g_m].waddr)])
                ews = 8'b1 << hb_id(m_in[g_m].waddr);
            if (m_in[g_m].write && !map_v[hb_id(m_in[g_m].waddr)]) ee[g_m] = 1'b1;
            chk("bus_raddr", s_bus.raddr, m_in[g_m].raddr);
            chk("bus_waddr", s_bus.waddr, m_in[g_m].waddr);
            chk("bus_wdata", s_bus.wdata, m_in[g_m].wdata);
            chk("bus_width", s_bus.write_width, m_in[g_m].write_width);
        end else begin
            chk("bus_idle", s_bus, 64'd0);
        end
        if (rq.size() > 0 && rq[0].due == cyc) begin
            ev[rq[0].m] = 1'b1;
            if (rq[0].unmapped) begin
                ee[rq[0].m] = 1'b1;
`ifdef XT_HB_DECERR_EN
                ed = 32'hDEADBEEF;
`endif
            end else begin
                ed = s_rdata[rq[0].id];
            end
        end
        chk("grant", m_grant, eg);
        chk("rd_sel", s_rd_sel, ers);
        chk("wr_sel", s_wr_sel, ews);
        chk("rvalid", m_rvalid, ev);
        chk("rdata", m_rdata, ed);
`ifdef XT_HB_DECERR_EN
        chk("err", m_err, ee);
`endif
    endtask

    task automatic advance();
        if (g_m >= 0) begin
            ptr = (g_m + 1) % N;
            if (m_in[g_m].read)
                rq.push_back('{cyc + L, g_m, hb_id(m_in[g_m].raddr),
                               !map_v[hb_id(m_in[g_m].raddr)]});
            pend[g_m] = 1'b0;
        end
        if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input bit rd, input bit wr, input logic [14:0] ra,
                           input logic [14:0] wa, input logic [31:0] wd, input logic [1:0] ww);
        m_in[i].read        = rd;
        m_in[i].write       = wr;
        m_in[i].raddr       = ra;
        m_in[i].waddr       = wa;
        m_in[i].wdata       = wd;
        m_in[i].write_width = ww;
    endtask

    task automatic idle_all();
        for (int i = 0; i < N; i++) begin
            m_in[i] = '0;
            pend[i] = 1'b0;
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            settle();
            advance();
        end
    endtask

    initial begin
        idle_all();
        for (int s = 0; s < 8; s++) s_rdata[s] = 32'(s) * 32'h01010101;
        @(negedge clk);

        // Reset held with a pending request: nothing may be granted.
        set_req(0, 1'b0, 1'b1, 15'h0000, 15'h0123, 32'h1, 2'd0);
        settle();
        chk("reset_grant_lit", m_grant, 2'b00);
        chk("reset_wrsel_lit", s_wr_sel, 8'h00);
        advance();
        step(1);
        rst_n = 1'b1;

        // Both masters requesting continuously alternate M0, M1, M0, M1.
        set_req(0, 1'b0, 1'b1, 15'h0000, 15'h0123, 32'h11, 2'd0);
        set_req(1, 1'b0, 1'b1, 15'h0000, 15'h0456, 32'h22, 2'd1);
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("alternate_lit", m_grant, (k % 2 == 0) ? 2'b01 : 2'b10);
            advance();
        end
        idle_all();

        // M1 reads ID 1; data returns L cycles later.
        s_rdata[1] = 32'hCAFE0001;
        set_req(1, 1'b1, 1'b0, 15'h1004, 15'h0, 32'h0, 2'd0);
        settle();
        chk("rd_id1_sel_lit", s_rd_sel, 8'h02);
        chk("rd_id1_grant_lit", m_grant, 2'b10);
        advance();
        idle_all();
        settle();
        chk("rd_id1_early_lit", m_rvalid, 2'b00);
        advance();
        settle();
        chk("rd_id1_rvalid_lit", m_rvalid, 2'b10);
        chk("rd_id1_rdata_lit", m_rdata, 32'hCAFE0001);
        advance();

        // Back-to-back reads from different masters return in order.
        s_rdata[0] = 32'hA5A50000;
        s_rdata[3] = 32'h5A5A0003;
        set_req(0, 1'b1, 1'b0, 15'h0008, 15'h0, 32'h0, 2'd0);
        step(1);
        idle_all();
        set_req(1, 1'b1, 1'b0, 15'h3000, 15'h0, 32'h0, 2'd0);
        step(1);
        idle_all();
        settle();
        chk("b2b_first_v_lit", m_rvalid, 2'b01);
        chk("b2b_first_d_lit", m_rdata, 32'hA5A50000);
        advance();
        settle();
        chk("b2b_second_v_lit", m_rvalid, 2'b10);
        chk("b2b_second_d_lit", m_rdata, 32'h5A5A0003);
        advance();

        // Write to ID 7.
        set_req(0, 1'b0, 1'b1, 15'h0, 15'h7010, 32'h12345678, 2'd2);
        settle();
        chk("wr_sel_lit", s_wr_sel, 8'h80);
        chk("wr_rdsel_lit", s_rd_sel, 8'h00);
        chk("wr_waddr_lit", s_bus.waddr, 15'h7010);
        chk("wr_wdata_lit", s_bus.wdata, 32'h12345678);
        chk("wr_width_lit", s_bus.write_width, 2'd2);
        advance();
        idle_all();
        step(1);
        settle();
        chk("wr_no_return_lit", m_rvalid, 2'b00);
        advance();

        // Read in flight is dropped by reset; pointer returns to M0.
        set_req(0, 1'b1, 1'b0, 15'h1000, 15'h0, 32'h0, 2'd0);
        step(1);
        idle_all();
        rst_n = 1'b0;
        settle();
        chk("rst_grant_lit", m_grant, 2'b00);
        chk("rst_rvalid_lit", m_rvalid, 2'b00);
        chk("rst_rdata_lit", m_rdata, 32'h0);
        chk("rst_bus_lit", s_bus, 64'd0);
        advance();
        settle();
        chk("rst_dropped_lit", m_rvalid, 2'b00);
        advance();
        rst_n = 1'b1;
        set_req(0, 1'b0, 1'b1, 15'h0, 15'h0100, 32'h5, 2'd0);
        set_req(1, 1'b0, 1'b1, 15'h0, 15'h0200, 32'h6, 2'd0);
        settle();
        chk("post_rst_m0_lit", m_grant, 2'b01);
        advance();
        idle_all();

        // Unmapped ID 5: granted, no select; read still returns.
        set_req(0, 1'b1, 1'b0, 15'h5000, 15'h0, 32'h0, 2'd0);
        settle();
        chk("unmap_rdsel_lit", s_rd_sel, 8'h00);
        chk("unmap_grant_lit", m_grant, 2'b01);
        advance();
        idle_all();
        step(1);
        settle();
        chk("unmap_rvalid_lit", m_rvalid, 2'b01);
`ifdef XT_HB_DECERR_EN
        chk("unmap_rdata_lit", m_rdata, 32'hDEADBEEF);
        chk("unmap_err_lit", m_err, 2'b01);
`else
        chk("unmap_rdata_lit", m_rdata, 32'h0);
`endif
        advance();
        set_req(1, 1'b0, 1'b1, 15'h0, 15'h5555, 32'h9, 2'd1);
        settle();
        chk("unmap_wrsel_lit", s_wr_sel, 8'h00);
`ifdef XT_HB_DECERR_EN
        chk("unmap_wr_err_lit", m_err, 2'b10);
`endif
        advance();
        idle_all();

        // Simultaneous read and write drive both selects.
        set_req(0, 1'b1, 1'b1, 15'h2000, 15'h3000, 32'h77, 2'd3);
        settle();
        chk("rw_rdsel_lit", s_rd_sel, 8'h04);
        chk("rw_wrsel_lit", s_wr_sel, 8'h08);
        advance();
        idle_all();
        step(3);

        // Randomized traffic; masters hold requests until granted.
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            for (int s = 0; s < 8; s++) s_rdata[s] = $urandom;
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 9) < 6) begin
                        int kind;
                        kind = $urandom_range(0, 2);
                        set_req(i, kind != 1, kind != 0, 15'($urandom), 15'($urandom),
                                $urandom, 2'($urandom));
                        pend[i] = 1'b1;
                    end else begin
                        m_in[i] = '0;
                    end
                end
            end
            step(1);
        end
        rst_n = 1'b1;
        idle_all();
        step(L + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
